// File: rtl/dpram_be_clr.sv
`default_nettype none
// ============================================================================
//  Module   : dpram_be_clr
//  Brief    : True dual-port RAM with byte enables, 1/2-cycle read latency,
//             port-A-wins collision merge and a full-array clear engine.
//  Revision : 1.0  initial release
// ============================================================================
module dpram_be_clr #(
    parameter int                    DATAWIDTH      = 8,
    parameter int                    ADDRWIDTH      = 8,
    parameter int                    BYTEWIDTH      = 8,
    parameter int                    OUTREG         = 0,
    parameter logic [DATAWIDTH-1:0]  FILL           = '0,
    parameter int                    CLEAR_ON_RESET = 1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             clear,
    output logic                             busy,
    output logic                             collision,
    input  logic [ADDRWIDTH-1:0]             address_a,
    input  logic [DATAWIDTH-1:0]             data_a,
    input  logic                             wren_a,
    input  logic [DATAWIDTH/BYTEWIDTH-1:0]   byteena_a,
    output logic [DATAWIDTH-1:0]             q_a,
    input  logic [ADDRWIDTH-1:0]             address_b,
    input  logic [DATAWIDTH-1:0]             data_b,
    input  logic                             wren_b,
    input  logic [DATAWIDTH/BYTEWIDTH-1:0]   byteena_b,
    output logic [DATAWIDTH-1:0]             q_b
);

    localparam int                   c_NB       = DATAWIDTH / BYTEWIDTH;
    localparam int                   c_DEPTH    = 2 ** ADDRWIDTH;
    localparam logic [ADDRWIDTH-1:0] c_PTR_ONE  = {{(ADDRWIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDRWIDTH-1:0] c_PTR_LAST = '1;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t                 r_state;
    logic                   r_busy;
    logic [ADDRWIDTH-1:0]   r_ptr;
    logic [DATAWIDTH-1:0]   r_mem [0:c_DEPTH-1];
    logic [DATAWIDTH-1:0]   r_q_a;
    logic [DATAWIDTH-1:0]   r_q_b;
    logic                   r_collision;

    logic [c_NB-1:0]        w_we_a;
    logic [c_NB-1:0]        w_we_b;
    logic [ADDRWIDTH-1:0]   w_addr_a;
    logic [DATAWIDTH-1:0]   w_din_a;
    logic [DATAWIDTH-1:0]   w_rd_a;
    logic [DATAWIDTH-1:0]   w_rd_b;
    logic [DATAWIDTH-1:0]   w_merge_a;
    logic [DATAWIDTH-1:0]   w_merge_b;
    logic                   w_coll;

    // Clear engine: a pointer sweep that borrows the port A write path.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
            r_busy  <= (CLEAR_ON_RESET != 0);
            r_ptr   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (clear) begin
                        r_state <= S_CLEAR;
                        r_busy  <= 1'b1;
                        r_ptr   <= '0;
                    end
                end
                S_CLEAR: begin
                    r_ptr <= r_ptr + c_PTR_ONE;
                    if (r_ptr == c_PTR_LAST) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_addr_a = r_busy ? r_ptr : address_a;
        w_din_a  = r_busy ? FILL  : data_a;
        w_we_a   = '0;
        w_we_b   = '0;
        if (!reset) begin
            if (r_busy) begin
                w_we_a = '1;
            end else begin
                w_we_a = wren_a ? byteena_a : '0;
                w_we_b = wren_b ? byteena_b : '0;
            end
        end
    end

    // Port B lanes are written first so overlapping port A lanes take priority.
    always_ff @(posedge clock) begin
        for (int i = 0; i < c_NB; i++) begin
            if (w_we_b[i]) begin
                r_mem[address_b][i*BYTEWIDTH +: BYTEWIDTH] <= data_b[i*BYTEWIDTH +: BYTEWIDTH];
            end
            if (w_we_a[i]) begin
                r_mem[w_addr_a][i*BYTEWIDTH +: BYTEWIDTH] <= w_din_a[i*BYTEWIDTH +: BYTEWIDTH];
            end
        end
    end

    assign w_rd_a = r_mem[address_a];
    assign w_rd_b = r_mem[address_b];
    assign w_coll = !r_busy && wren_a && wren_b && (address_a == address_b);

    // Each port sees its own write; on a collision both see the final word.
    always_comb begin
        w_merge_a = w_rd_a;
        w_merge_b = w_rd_b;
        for (int i = 0; i < c_NB; i++) begin
            if (wren_a && byteena_a[i]) begin
                w_merge_a[i*BYTEWIDTH +: BYTEWIDTH] = data_a[i*BYTEWIDTH +: BYTEWIDTH];
            end else if (w_coll && byteena_b[i]) begin
                w_merge_a[i*BYTEWIDTH +: BYTEWIDTH] = data_b[i*BYTEWIDTH +: BYTEWIDTH];
            end
            if (wren_b && byteena_b[i]) begin
                w_merge_b[i*BYTEWIDTH +: BYTEWIDTH] = data_b[i*BYTEWIDTH +: BYTEWIDTH];
            end
        end
        if (w_coll) begin
            w_merge_b = w_merge_a;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || r_busy) begin
            r_q_a       <= '0;
            r_q_b       <= '0;
            r_collision <= 1'b0;
        end else begin
            r_q_a       <= w_merge_a;
            r_q_b       <= w_merge_b;
            r_collision <= w_coll;
        end
    end

    generate
        if (OUTREG != 0) begin : g_outreg
            logic [DATAWIDTH-1:0] r_q_a_d;
            logic [DATAWIDTH-1:0] r_q_b_d;

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_q_a_d <= '0;
                    r_q_b_d <= '0;
                end else begin
                    r_q_a_d <= r_q_a;
                    r_q_b_d <= r_q_b;
                end
            end

            assign q_a = r_q_a_d;
            assign q_b = r_q_b_d;
        end else begin : g_direct
            assign q_a = r_q_a;
            assign q_b = r_q_b;
        end
    endgenerate

    assign busy      = r_busy;
    assign collision = r_collision;

endmodule
`default_nettype wire

// File: doc/dpram_be_clr.md
Name: dpram_be_clr

Overview:
- Parametrised true dual-port synchronous RAM. Both ports can read and write.
- Adds per-byte write enables, selectable read latency (1 or 2 cycles), and a defined same-address write-collision policy.
- Includes a hardware clear engine that sweeps the whole array to a fill value, either after reset or on request.
- Used wherever video/attribute buffers and CPU-shared tables must start from a known state without a preload file.

Parameters:
- DATAWIDTH, 8, data word width in bits; must be a multiple of BYTEWIDTH.
- ADDRWIDTH, 8, address width; depth = 2**ADDRWIDTH words.
- BYTEWIDTH, 8, bits per byte-enable lane; NB = DATAWIDTH/BYTEWIDTH lanes.
- OUTREG, 0, 0 = read latency 1 cycle; 1 = extra output register, latency 2 cycles.
- FILL, 0, DATAWIDTH-bit value written to every word by the clear engine.
- CLEAR_ON_RESET, 1, 1 = start a full clear automatically when reset is released.

Ports:
- clock  in  1  single system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- clear  in  1  one-cycle request to start a full clear; sampled only in IDLE.
- busy  out  1  high while the clear engine owns the array.
- collision  out  1  one-cycle pulse: both ports wrote the same address in the same cycle.
- address_a  in  ADDRWIDTH  port A address.
- data_a  in  DATAWIDTH  port A write data.
- wren_a  in  1  port A write strobe.
- byteena_a  in  NB  port A lane enables; lane i covers bits [i*BYTEWIDTH +: BYTEWIDTH].
- q_a  out  DATAWIDTH  port A read data.
- address_b, data_b, wren_b, byteena_b, q_b: port B, identical definitions.

Behaviour:
- Reset (synchronous, active-high) while reset=1:
  - q_a, q_b, all output pipeline registers, collision: 0.
  - Clear pointer: 0.
  - State: CLEAR if CLEAR_ON_RESET=1, else IDLE.
  - busy = CLEAR_ON_RESET.
  - Array contents are not altered while reset is held.
- Reset asserted mid-clear restarts the sweep at address 0 (when CLEAR_ON_RESET=1), or abandons it into IDLE (when 0).
- FSM has two states, IDLE and CLEAR.
- IDLE -> CLEAR: on clear=1. Pointer loads 0, busy=1 from the next cycle.
- CLEAR cycle behaviour:
  - Writes FILL to mem[pointer], all lanes, then increments the pointer.
  - Writing address 2**ADDRWIDTH-1 ends the sweep: next state IDLE, busy=0 on the following cycle.
  - A full clear occupies exactly 2**ADDRWIDTH cycles with busy=1.
  - clear=1 while in CLEAR is ignored (no restart).
- While busy=1:
  - Port writes are discarded.
  - q_a/q_b load 0.
  - collision stays 0.
- Normal read/write (IDLE, per port):
  - wren=0: q <= mem[address] at the next edge.
  - wren=1: only lanes with byteena=1 are written.
  - q <= merged word (new data in enabled lanes, previous contents elsewhere), i.e. write-first on the own port.
  - wren=1 with byteena=0: no memory change; q returns the current contents.
- Cross-port visibility:
  - A read on one port while the other port writes the same address returns the pre-write contents.
  - The new value is visible from the next cycle.
- Collision (both wren=1, address_a==address_b):
  - Lanes enabled on A take data_a (port A wins).
  - Lanes enabled only on B take data_b.
  - Other lanes are unchanged.
  - Both q_a and q_b return the final stored word.
  - collision=1 on the next edge for one cycle, regardless of overlapping lanes.
- OUTREG=1: q_a/q_b pass through one more register (reset 0).
  - Total latency from address to q is 2 cycles.
  - collision timing is unchanged (1 cycle).
- Address wrap is natural: no out-of-range addresses exist.
- Array inference must remain block-RAM compatible on both ports.

Test Plan:
- Reset with CLEAR_ON_RESET=1, FILL=8'hA5, ADDRWIDTH=4 -> busy=1 for exactly 16 cycles after reset drops; afterwards reads of addresses 0..15 all return 8'hA5.
- DATAWIDTH=16, IDLE: A writes 16'h1234 to addr 3 (byteena 2'b11), then B writes 16'hFF00 with byteena 2'b10 -> q_b=16'hFF34 next cycle; A reads addr 3 -> 16'hFF34.
- Same-cycle writes to addr 5: A data 16'hAAAA byteena 2'b01, B data 16'hBBBB byteena 2'b11 -> stored/q_a/q_b=16'hBBAA; collision=1 for one cycle.
- B reads addr 7 (contents 16'h0001) while A writes 16'h0002 there -> q_b=16'h0001; next-cycle read gives 16'h0002.
- clear pulse in IDLE, then port writes during busy -> writes discarded, q=0; reset asserted mid-sweep -> sweep restarts at 0 and full 2**ADDRWIDTH busy window repeats.
- OUTREG=1: read addr 2 (contents 8'h5C) -> q_a=8'h5C exactly 2 cycles after the address is applied; q_a=0 during the cycle after reset.
